// File: rtl/pulse_capture_sequencer.sv
// Arms on request, waits for a rising edge on detectPulse, then captures a burst
// of samples into a first-word-fall-through buffer drained through a valid/ready port.
module pulse_capture_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  arm,
    input  logic [3:0]            burstLen,
    input  logic                  detectPulse,
    input  logic [DATA_WIDTH-1:0] incomingData,
    output logic [DATA_WIDTH-1:0] outData,
    output logic                  outValid,
    input  logic                  outReady,
    output logic                  busy,
    output logic                  overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DRAIN} state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic                  r_p1Detect;
    logic [4:0]            r_count;
    logic                  r_overflow;
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]           r_wrPtr;
    logic [AW:0]           r_rdPtr;

    logic w_rise;
    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_wrEn;
    logic w_drop;
    logic w_accept;
    logic w_lastWord;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_empty    = (r_wrPtr == r_rdPtr);
    assign w_full     = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                        (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
    assign w_rise     = detectPulse & ~r_p1Detect;
    assign w_pop      = outValid & outReady;
    assign w_accept   = (r_state == IDLE) && arm;
    assign w_lastWord = (r_count == 5'd1);
    assign w_push     = ((r_state == ARMED) && w_rise) || (r_state == CAPTURE);
    assign w_wrEn     = w_push && (!w_full || w_pop);
    assign w_drop     = w_push && w_full && !w_pop;

    assign outValid = ~w_empty;
    assign outData  = w_empty ? '0 : r_mem[r_rdPtr[AW-1:0]];
    assign busy     = (r_state != IDLE);
    assign overflow = r_overflow;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (arm) w_nextState = ARMED;
            ARMED:   if (w_rise) w_nextState = w_lastWord ? DRAIN : CAPTURE;
            CAPTURE: if (w_lastWord) w_nextState = DRAIN;
            DRAIN:   if (w_empty) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Reset value of 1 keeps a line held high through reset release from counting as an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_p1Detect <= 1'b1;
            r_count    <= 5'd0;
            r_overflow <= 1'b0;
        end else begin
            r_p1Detect <= detectPulse;
            if (w_accept) begin
                r_count    <= (burstLen == 4'd0) ? 5'd16 : {1'b0, burstLen};
                r_overflow <= 1'b0;
            end else begin
                if (w_push) r_count <= r_count - 5'd1;
                if (w_drop) r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_wrEn) r_wrPtr <= r_wrPtr + PTR_ONE;
            if (w_pop)  r_rdPtr <= r_rdPtr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wrEn) r_mem[r_wrPtr[AW-1:0]] <= incomingData;
    end

endmodule

// File: tb/tb_pulse_capture_sequencer.sv
// Directed and randomized bench for pulse_capture_sequencer, checked every cycle
// against a queue-based reference model of the capture/buffer behaviour.
module tb_pulse_capture_sequencer;

    localparam int DW    = 16;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          arm;
    logic [3:0]    burstLen;
    logic          detectPulse;
    logic [DW-1:0] incomingData;
    logic [DW-1:0] outData;
    logic          outValid;
    logic          outReady;
    logic          busy;
    logic          overflow;

    int compareCount = 0;
    int failCount    = 0;
    int popCount     = 0;

    logic [DW-1:0] mQ[$];
    int            mMode;
    int            mLeft;
    logic          mOvf;
    logic          mPrevDet;

    always #5 clk = ~clk;

    pulse_capture_sequencer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .arm(arm), .burstLen(burstLen),
        .detectPulse(detectPulse), .incomingData(incomingData),
        .outData(outData), .outValid(outValid), .outReady(outReady),
        .busy(busy), .overflow(overflow)
    );

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compareCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [31:0] expData;
        expData = (mQ.size() > 0) ? 32'(mQ[0]) : 32'd0;
        checkValue({tag, ".outValid"}, 32'(outValid), 32'(mQ.size() > 0));
        checkValue({tag, ".outData"},  32'(outData),  expData);
        checkValue({tag, ".busy"},     32'(busy),     32'(mMode != 0));
        checkValue({tag, ".overflow"}, 32'(overflow), 32'(mOvf));
    endtask

    // Mode: 0 idle, 1 waiting for trigger, 2 capturing, 3 draining
    task automatic modelStep();
        int   sizeNow;
        logic canPop;
        logic edgeSeen;
        logic wantWrite;
        sizeNow   = mQ.size();
        canPop    = (sizeNow > 0) && outReady;
        edgeSeen  = detectPulse && !mPrevDet;
        wantWrite = ((mMode == 1) && edgeSeen) || (mMode == 2);
        if (mMode == 3 && sizeNow == 0) begin
            mMode = 0;
        end else if (mMode == 0 && arm) begin
            mMode = 1;
            mLeft = (burstLen == 4'd0) ? 16 : int'(burstLen);
            mOvf  = 1'b0;
        end
        if (canPop) void'(mQ.pop_front());
        if (wantWrite) begin
            if (sizeNow < DEPTH || canPop) mQ.push_back(incomingData);
            else mOvf = 1'b1;
            mLeft--;
            mMode = (mLeft == 0) ? 3 : 2;
        end
        mPrevDet = detectPulse;
    endtask

    task automatic modelReset();
        mQ.delete();
        mMode    = 0;
        mLeft    = 0;
        mOvf     = 1'b0;
        mPrevDet = 1'b1;
    endtask

    // Called at a falling edge: drive, check, advance the model, step one clock.
    task automatic applyStimulus(input string tag, input logic a, input logic [3:0] bl,
                                 input logic d, input logic [DW-1:0] x, input logic r);
        arm = a; burstLen = bl; detectPulse = d; incomingData = x; outReady = r;
        #1;
        checkOutput(tag);
        if (outValid && outReady) popCount++;
        modelStep();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulseReset(input string tag, input logic detDuringReset);
        reset = 1'b0;
        detectPulse = detDuringReset;
        arm = 1'b0;
        #1;
        modelReset();
        checkOutput(tag);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic idleCycles(input string tag, input int n, input logic r);
        for (int i = 0; i < n; i++) applyStimulus(tag, 1'b0, 4'd0, 1'b0, DW'(i), r);
    endtask

    initial begin
        reset = 1'b0; arm = 1'b0; burstLen = 4'd0; detectPulse = 1'b0;
        incomingData = '0; outReady = 1'b0;
        modelReset();
        @(negedge clk);
        #1;
        checkOutput("reset");
        @(negedge clk);
        reset = 1'b1;

        // Basic 4-word burst with a free-running consumer
        applyStimulus("b4.arm", 1'b1, 4'd4, 1'b0, 16'h0000, 1'b1);
        applyStimulus("b4.wait", 1'b0, 4'd4, 1'b0, 16'h0000, 1'b1);
        applyStimulus("b4.w0", 1'b0, 4'd4, 1'b1, 16'h0010, 1'b1);
        applyStimulus("b4.w1", 1'b0, 4'd4, 1'b0, 16'h0011, 1'b1);
        applyStimulus("b4.w2", 1'b0, 4'd4, 1'b1, 16'h0012, 1'b1);
        applyStimulus("b4.w3", 1'b0, 4'd4, 1'b0, 16'h0013, 1'b1);
        idleCycles("b4.tail", 4, 1'b1);

        // 16-word burst into a stalled consumer, then drain
        popCount = 0;
        applyStimulus("ovf.arm", 1'b1, 4'd0, 1'b0, 16'h0000, 1'b0);
        applyStimulus("ovf.w", 1'b0, 4'd0, 1'b1, 16'h0100, 1'b0);
        for (int i = 1; i < 16; i++)
            applyStimulus("ovf.w", 1'b0, 4'd0, 1'b0, DW'(16'h0100 + i), 1'b0);
        applyStimulus("ovf.hold", 1'b0, 4'd0, 1'b0, 16'h0000, 1'b0);
        idleCycles("ovf.drain", 12, 1'b1);
        checkValue("ovf.emitted", 32'(popCount), 32'd8);

        // Trigger held high through arm must not start a capture
        applyStimulus("held.pre", 1'b0, 4'd2, 1'b1, 16'h0200, 1'b1);
        applyStimulus("held.arm", 1'b1, 4'd2, 1'b1, 16'h0201, 1'b1);
        applyStimulus("held.high", 1'b0, 4'd2, 1'b1, 16'h0202, 1'b1);
        applyStimulus("held.high", 1'b0, 4'd2, 1'b1, 16'h0203, 1'b1);
        applyStimulus("held.low", 1'b0, 4'd2, 1'b0, 16'h0204, 1'b1);
        applyStimulus("held.rise", 1'b0, 4'd2, 1'b1, 16'h0205, 1'b1);
        applyStimulus("held.w1", 1'b0, 4'd2, 1'b1, 16'h0206, 1'b1);
        idleCycles("held.tail", 4, 1'b1);

        // Full buffer with concurrent pops; late arm pulses with new length ignored
        applyStimulus("full.arm", 1'b1, 4'd0, 1'b0, 16'h0000, 1'b0);
        applyStimulus("full.w", 1'b0, 4'd0, 1'b1, 16'h0300, 1'b0);
        for (int i = 1; i < 8; i++)
            applyStimulus("full.w", 1'b0, 4'd0, 1'b0, DW'(16'h0300 + i), 1'b0);
        for (int i = 8; i < 16; i++)
            applyStimulus("full.wpop", i[0], 4'd3, 1'b0, DW'(16'h0300 + i), 1'b1);
        applyStimulus("full.drainarm", 1'b1, 4'd3, 1'b0, 16'h0000, 1'b1);
        idleCycles("full.drain", 10, 1'b1);

        // Reset after two of six words; trigger high across release
        applyStimulus("rst.arm", 1'b1, 4'd6, 1'b0, 16'h0000, 1'b0);
        applyStimulus("rst.w0", 1'b0, 4'd6, 1'b1, 16'h0400, 1'b0);
        applyStimulus("rst.w1", 1'b0, 4'd6, 1'b1, 16'h0401, 1'b0);
        pulseReset("rst.mid", 1'b1);
        @(negedge clk);
        applyStimulus("rst.after", 1'b0, 4'd6, 1'b1, 16'h0402, 1'b1);
        applyStimulus("rst.rearm", 1'b1, 4'd1, 1'b1, 16'h0403, 1'b1);
        applyStimulus("rst.high", 1'b0, 4'd1, 1'b1, 16'h0404, 1'b1);
        applyStimulus("rst.low", 1'b0, 4'd1, 1'b0, 16'h0405, 1'b1);
        applyStimulus("rst.rise", 1'b0, 4'd1, 1'b1, 16'h0406, 1'b1);
        idleCycles("rst.tail", 4, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 400; i++)
            applyStimulus("rand", ($urandom_range(0, 7) == 0), 4'($urandom),
                          ($urandom_range(0, 2) == 0), DW'($urandom),
                          ($urandom_range(0, 3) != 0));
        for (int i = 0; i < 40; i++)
            applyStimulus("rand.drain", 1'b0, 4'd0, 1'b0, DW'($urandom), 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule

// File: doc/pulse_capture_sequencer.md
PULSE_CAPTURE_SEQUENCER -- requirements
Module: pulse_capture_sequencer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, the width of sampled data.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8, the output buffer depth in words, a power of two, at least 2.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 The block SHALL have port arm  input  1  one-cycle request to arm a capture.
REQ-006 The block SHALL have port burstLen  input  4  words per capture, sampled on accepted arm; 0 means 16.
REQ-007 The block SHALL have port detectPulse  input  1  trigger line; a rising edge starts capture.
REQ-008 The block SHALL have port incomingData  input  DATA_WIDTH  sample stream, one word per cycle.
REQ-009 The block SHALL have port outData  output  DATA_WIDTH  head-of-buffer word.
REQ-010 The block SHALL have port outValid  output  1  outData holds a valid word.
REQ-011 The block SHALL have port outReady  input  1  consumer accepts outData when outValid is high.
REQ-012 The block SHALL have port busy  output  1  high whenever the FSM is not IDLE.
REQ-013 The block SHALL have port overflow  output  1  sticky flag: at least one captured word was dropped.

Function
REQ-014 The block SHALL keep a registered copy p1_detectPulse of detectPulse, updated every cycle in all states; rising edge = detectPulse & !p1_detectPulse.
REQ-015 The FSM SHALL have states IDLE, ARMED, CAPTURE and DRAIN.
REQ-016 In IDLE, arm=1 SHALL move the FSM to ARMED, load remaining count from burstLen (0 -> 16) and clear overflow.
REQ-017 arm SHALL be ignored in ARMED, CAPTURE and DRAIN.
REQ-018 In ARMED, a rising edge SHALL write incomingData of that same cycle as word 1 and move to CAPTURE, or directly to DRAIN if count is 1.
REQ-019 In CAPTURE, the block SHALL write incomingData each consecutive cycle, regardless of detectPulse, until count words in total are written, then move to DRAIN.
REQ-020 In DRAIN, the block SHALL move to IDLE in the first cycle the buffer is empty with no write pending.
REQ-021 The buffer SHALL be first-word-fall-through: outValid = buffer not empty; outData = oldest word.
REQ-022 A word SHALL be popped when outValid & outReady; outData SHALL not change while outValid=1 and outReady=0.
REQ-023 Latency: a word written at cycle t SHALL appear with outValid=1 at cycle t+1 if the buffer was empty.
REQ-024 Push into a full buffer SHALL succeed when a pop occurs the same cycle; otherwise the word SHALL be dropped, overflow set, and count still decremented.
REQ-025 Simultaneous push and pop on empty buffer is not possible (outValid=0); push proceeds normally.
REQ-026 Pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL be distinguished with an extra pointer bit or occupancy counter.
REQ-027 overflow SHALL stay set until the next accepted arm or reset.

Reset
REQ-028 While reset=0: FSM = IDLE, buffer empty, outValid=0, busy=0, overflow=0, outData=0, count=0.
REQ-029 p1_detectPulse SHALL reset to 1 so a detectPulse held high through reset release is not an edge.
REQ-030 Reset asserted mid-capture SHALL discard all buffered words immediately; no words SHALL be emitted after release.

Verification
REQ-031 arm, burstLen=4, outReady=1; detectPulse rises at cycle t with data 0x0010,0x0011,0x0012,0x0013 -> four words out at t+1..t+4 in order, overflow=0, busy falls after the last.
REQ-032 burstLen=0, outReady=0, FIFO_DEPTH=8 -> 8 words buffered, 8 dropped, overflow=1; then outReady=1 -> exactly the first 8 words emitted, FSM returns IDLE.
REQ-033 detectPulse held high before and during arm -> no capture until it goes low then high again.
REQ-034 Buffer full, outReady=1 during CAPTURE -> no word dropped, overflow stays 0.
REQ-035 Reset pulsed low in CAPTURE after 2 of 6 words -> outValid=0, busy=0 immediately; detectPulse high at release -> no capture.
REQ-036 arm pulsed during CAPTURE and DRAIN -> ignored; burstLen change has no effect until next IDLE arm.
